xadc_multi_channel_monitor: RTL
===============================

// Module: xadc_multi_channel_monitor
// PURPOSE
//  DRP read sequencer for the on-chip XADC. Sits between the xadc_wiz EOC/DRP pins and the
//  DCS status logic. For each end-of-conversion on a mapped channel it reads the result over
//  DRP and averages 2^AVG_LOG2 samples per channel. It holds the latest average per channel
//  and raises sticky high/low threshold alarms. It also flags DRP timeouts and dropped conversions.
// PARAMETERS
//  N_CH          4                            number of monitored channels (1..8)
//  ADC_BITS      12                           result width taken from do_in[15:16-ADC_BITS]
//  AVG_LOG2      2                            samples averaged per result = 2^AVG_LOG2 (0..4)
//  CH_MAP        {5'h06,5'h02,5'h01,5'h00}    packed N_CH x 5b XADC channel numbers; entry 0 in LSBs
//  DRDY_TIMEOUT  64                           max cycles from den_out to drdy_in
// PORTS
//  clk               in   1             DRP/system clock
//  reset             in   1             asynchronous, active-high reset
//  eoc_in            in   1             XADC end-of-conversion pulse
//  channel_in        in   5             XADC channel_out, valid with eoc_in
//  den_out           out  1             DRP enable, 1-cycle pulse
//  daddr_out         out  7             DRP address = {2'b00, channel}
//  dwe_out           out  1             DRP write enable, constant 0
//  drdy_in           in   1             DRP data ready
//  do_in             in   16            DRP read data
//  thr_hi_in         in   N_CH*ADC_BITS upper thresholds; channel i at [i*ADC_BITS +: ADC_BITS]
//  thr_lo_in         in   N_CH*ADC_BITS lower thresholds; same packing
//  clear_in          in   1             sync clear of alarms, errors, accumulators, overrun count
//  rd_sel_in         in   clog2(N_CH)   result register-file read index (min width 1)
//  rd_data_out       out  ADC_BITS      latest average of channel rd_sel_in, registered
//  result_valid_out  out  1             1-cycle pulse: new average produced
//  result_ch_out     out  clog2(N_CH)   map index of the new average
//  result_data_out   out  ADC_BITS      new average value
//  alarm_hi_out      out  N_CH          sticky: average > thr_hi
//  alarm_lo_out      out  N_CH          sticky: average < thr_lo
//  alarm_any_out     out  1             OR of all alarm bits
//  timeout_err_out   out  1             sticky: drdy missing after DRDY_TIMEOUT cycles
//  overrun_cnt_out   out  8             saturating count of dropped eoc_in pulses
//  busy_out          out  1             FSM not in IDLE
// BEHAVIOUR
//  Reset: all outputs, accumulators, sample counters and the result file are 0. FSM goes to IDLE.
//  FSM states:
//   IDLE: eoc_in=1 and channel_in matches a CH_MAP entry -> REQ. Latch the map index.
//    Duplicate CH_MAP entries: lowest index wins. Unmapped channel: no DRP access.
//   REQ: den_out=1 and daddr_out valid for exactly one cycle -> WAIT.
//    With eoc_in at cycle T, den_out is high at T+1.
//   WAIT: capture do_in on drdy_in -> ACC. The timeout counter starts at the den cycle.
//    If drdy_in is not seen by DRDY_TIMEOUT cycles: set timeout_err, discard the sample, -> IDLE.
//   ACC: acc[i] += sample and cnt[i]++ -> IDLE.
//    Sample = do_in[15:16-ADC_BITS]. Accumulator width = ADC_BITS+AVG_LOG2, with no overflow.
//    When cnt[i] reaches 2^AVG_LOG2: avg = floor(sum >> AVG_LOG2). Write avg to the result
//    file, then clear acc[i] and cnt[i].
//    On that same edge: pulse result_valid_out, drive result_ch/result_data, and update alarms.
//    With drdy_in at cycle D, result_valid_out is high at D+2.
//  Alarms: strict compare; equality raises no alarm. Alarm bits are sticky until clear_in or reset.
//  eoc_in in any state other than IDLE: dropped, no DRP access. overrun_cnt increments and
//   saturates at 255. Mapped and unmapped channels are counted alike.
//  drdy_in outside WAIT is ignored.
//  clear_in: FSM -> IDLE. Zero accumulators, counters, alarms, timeout_err and overrun_cnt.
//   The result file is retained.
//   An alarm or timeout condition on the same edge as clear_in is set, not cleared (event wins).
//  rd_data_out = result_file[rd_sel_in], registered: 1 cycle latency.
//   rd_sel_in >= N_CH reads 0.
//  Async reset mid-transaction: the pending DRP read is abandoned; any later drdy_in is ignored.
// TESTING
//  1. Ch 0x00 eoc x4 with do_in=0x9770 (code 2423, 25 C), thr_hi=0xFFF, thr_lo=0
//     -> den at T+1, daddr=0x00; one result_valid with ch=0, data=0x977; no alarms.
//  2. Ch 0x01 samples 0x100,0x101,0x102,0x104 (<<4), thr_hi=0x101
//     -> avg=0x101 (floor); alarm_hi[1] stays 0. Repeat with thr_hi=0x100 -> alarm_hi[1]=1, alarm_any=1.
//  3. eoc_in on channel 0x05 (unmapped)
//     -> no den_out, no result, overrun_cnt unchanged.
//  4. drdy_in withheld after den
//     -> timeout_err=1 at den+64; FSM IDLE; next eoc serviced normally; acc unchanged.
//  5. 300 eoc_in pulses while in WAIT -> overrun_cnt=255.
//     Then clear_in -> overrun=0, alarms=0; rd_data_out still holds the old averages.
//  6. Assert reset during WAIT, release, then drive stray drdy_in
//     -> no result_valid, all outputs 0, busy_out=0.

Source files
------------

// File: rtl/xadc_multi_channel_monitor.sv
// ---------------------------------------------------------------------------
// xadc_multi_channel_monitor
//
// Purpose:
//   DRP read sequencer for the on-chip XADC. Each end-of-conversion on a mapped
//   channel triggers one DRP read. 2^AVG_LOG2 samples per channel are averaged.
//   The latest average per channel is kept in a small result file, and sticky
//   high/low threshold alarms, a sticky DRP timeout flag and a saturating count
//   of dropped conversions are maintained.
//
// Ports:
//   clk, reset            system/DRP clock, asynchronous active-high reset
//   eoc_in, channel_in    XADC end-of-conversion pulse and its channel number
//   den_out, daddr_out,
//   dwe_out               DRP request (read only, dwe_out tied low)
//   drdy_in, do_in        DRP read response
//   thr_hi_in, thr_lo_in  packed per-channel thresholds, channel i at [i*ADC_BITS +: ADC_BITS]
//   clear_in              synchronous clear of alarms, errors, accumulators, overrun count
//   rd_sel_in/rd_data_out registered read port into the result file
//   result_*_out          one-cycle notification of each new average
//   alarm_*_out           sticky threshold alarms and their OR
//   timeout_err_out       sticky DRP timeout flag
//   overrun_cnt_out       saturating count of eoc_in pulses dropped while busy
//   busy_out              sequencer not idle
// ---------------------------------------------------------------------------
module xadc_multi_channel_monitor #(
    parameter int                N_CH         = 4,
    parameter int                ADC_BITS     = 12,
    parameter int                AVG_LOG2     = 2,
    parameter logic [N_CH*5-1:0] CH_MAP       = {5'h06, 5'h02, 5'h01, 5'h00},
    parameter int                DRDY_TIMEOUT = 64,
    localparam int               SEL_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     eoc_in,
    input  logic [4:0]               channel_in,
    output logic                     den_out,
    output logic [6:0]               daddr_out,
    output logic                     dwe_out,
    input  logic                     drdy_in,
    input  logic [15:0]              do_in,
    input  logic [N_CH*ADC_BITS-1:0] thr_hi_in,
    input  logic [N_CH*ADC_BITS-1:0] thr_lo_in,
    input  logic                     clear_in,
    input  logic [SEL_W-1:0]         rd_sel_in,
    output logic [ADC_BITS-1:0]      rd_data_out,
    output logic                     result_valid_out,
    output logic [SEL_W-1:0]         result_ch_out,
    output logic [ADC_BITS-1:0]      result_data_out,
    output logic [N_CH-1:0]          alarm_hi_out,
    output logic [N_CH-1:0]          alarm_lo_out,
    output logic                     alarm_any_out,
    output logic                     timeout_err_out,
    output logic [7:0]               overrun_cnt_out,
    output logic                     busy_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_ACC  = 2'd3;

    localparam int ACC_W = ADC_BITS + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int TMR_W = $clog2(DRDY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRDY_TIMEOUT - 1);

    logic [1:0]          r_state;
    logic [SEL_W-1:0]    r_idx;
    logic [6:0]          r_daddr;
    logic [TMR_W-1:0]    r_timer;
    logic [ADC_BITS-1:0] r_sample;
    logic [ACC_W-1:0]    r_acc  [N_CH];
    logic [CNT_W-1:0]    r_cnt  [N_CH];
    logic [ADC_BITS-1:0] r_file [N_CH];
    logic                r_valid;
    logic [SEL_W-1:0]    r_res_ch;
    logic [ADC_BITS-1:0] r_res_data;
    logic [N_CH-1:0]     r_alarm_hi;
    logic [N_CH-1:0]     r_alarm_lo;
    logic                r_timeout;
    logic [7:0]          r_ovr;
    logic [ADC_BITS-1:0] r_rd_data;

    logic                w_hit;
    logic [SEL_W-1:0]    w_hit_idx;
    logic [ADC_BITS-1:0] w_thr_hi [N_CH];
    logic [ADC_BITS-1:0] w_thr_lo [N_CH];
    logic [ACC_W-1:0]    w_sum;
    logic                w_last;
    logic [ADC_BITS-1:0] w_avg;
    logic [N_CH-1:0]     w_hi_set;
    logic [N_CH-1:0]     w_lo_set;
    logic                w_timeout_set;
    logic                w_unused_do;

    // Channel lookup: scanning from the top down lets the lowest matching
    // map index win when CH_MAP holds duplicates.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -> no latch.
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (CH_MAP[i*5 +: 5] == channel_in) begin
                w_hit     = 1'b1;
                w_hit_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_thr_hi[i] = thr_hi_in[i*ADC_BITS +: ADC_BITS];
            w_thr_lo[i] = thr_lo_in[i*ADC_BITS +: ADC_BITS];
        end
    end

    // The accumulator is sized so 2^AVG_LOG2 full-scale samples cannot
    // overflow; the average is simply its top ADC_BITS bits.
    assign w_sum  = r_acc[r_idx] + ACC_W'(r_sample);
    assign w_last = (r_cnt[r_idx] == CNT_LAST);
    assign w_avg  = w_sum[ACC_W-1 -: ADC_BITS];

    always_comb begin
        w_hi_set = '0;
        w_lo_set = '0;
        if (r_state == S_ACC && w_last) begin
            w_hi_set[r_idx] = (w_avg > w_thr_hi[r_idx]);
            w_lo_set[r_idx] = (w_avg < w_thr_lo[r_idx]);
        end
    end

    assign w_timeout_set = (r_state == S_WAIT) && !drdy_in && (r_timer >= TMR_LAST);

    // Low result bits below the ADC code are not used.
    assign w_unused_do = ^do_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: non-blocking assignments throughout sequential logic so all
            // registers update from pre-edge values.
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_daddr    <= '0;
            r_timer    <= '0;
            r_sample   <= '0;
            r_valid    <= 1'b0;
            r_res_ch   <= '0;
            r_res_data <= '0;
            r_alarm_hi <= '0;
            r_alarm_lo <= '0;
            r_timeout  <= 1'b0;
            r_ovr      <= '0;
            // NOTE: the result file is a handful of flops, not RAM, so it is
            // reset with everything else to give a defined readback.
            for (int i = 0; i < N_CH; i++) begin
                r_acc[i]  <= '0;
                r_cnt[i]  <= '0;
                r_file[i] <= '0;
            end
        end else begin
            r_valid <= 1'b0;

            // Conversions arriving while a read is in flight are dropped.
            if (clear_in) begin
                r_ovr <= '0;
            end else if (eoc_in && r_state != S_IDLE && r_ovr != 8'hFF) begin
                r_ovr <= r_ovr + 8'd1;
            end

            // A new alarm or timeout on the clear edge survives the clear.
            r_alarm_hi <= (clear_in ? '0 : r_alarm_hi) | w_hi_set;
            r_alarm_lo <= (clear_in ? '0 : r_alarm_lo) | w_lo_set;
            r_timeout  <= (clear_in ? 1'b0 : r_timeout) | w_timeout_set;

            case (r_state)
                S_IDLE: begin
                    if (eoc_in && w_hit) begin
                        r_idx   <= w_hit_idx;
                        r_daddr <= {2'b00, channel_in};
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    // The den cycle itself counts as the first timeout cycle.
                    r_timer <= TMR_W'(1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (drdy_in) begin
                        r_sample <= do_in[15 -: ADC_BITS];
                        r_state  <= S_ACC;
                    end else if (w_timeout_set) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_ACC: begin
                    if (w_last) begin
                        r_file[r_idx] <= w_avg;
                        r_acc[r_idx]  <= '0;
                        r_cnt[r_idx]  <= '0;
                        r_valid       <= 1'b1;
                        r_res_ch      <= r_idx;
                        r_res_data    <= w_avg;
                    end else begin
                        r_acc[r_idx] <= w_sum;
                        r_cnt[r_idx] <= r_cnt[r_idx] + CNT_W'(1);
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // Clear overrides the sequencer and partial sums, not the result file.
            if (clear_in) begin
                r_state <= S_IDLE;
                for (int i = 0; i < N_CH; i++) begin
                    r_acc[i] <= '0;
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= (32'(rd_sel_in) < N_CH) ? r_file[rd_sel_in] : '0;
        end
    end

    assign den_out          = (r_state == S_REQ);
    assign daddr_out        = r_daddr;
    assign dwe_out          = 1'b0;
    assign rd_data_out      = r_rd_data;
    assign result_valid_out = r_valid;
    assign result_ch_out    = r_res_ch;
    assign result_data_out  = r_res_data;
    assign alarm_hi_out     = r_alarm_hi;
    assign alarm_lo_out     = r_alarm_lo;
    assign alarm_any_out    = |{r_alarm_hi, r_alarm_lo};
    assign timeout_err_out  = r_timeout;
    assign overrun_cnt_out  = r_ovr;
    assign busy_out         = (r_state != S_IDLE);

endmodule
